// File: rtl/cpu_pkg.sv
// Shared types for the ID/EX stage: ALU op codes, forwarding selects and the
// packed ID/EX pipeline register. Field widths follow CpuLen/CpuRegAw; the
// id_ex_stage LEN/REG_AW parameters default to these and must match them.
package cpu_pkg;

  localparam int unsigned CpuLen   = 32;
  localparam int unsigned CpuRegAw = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_SEQ   = 4'b1010,
    ALU_SNE   = 4'b1011,
    ALU_SGE   = 4'b1100,
    ALU_SGEU  = 4'b1101,
    ALU_AUIPC = 4'b1110,
    ALU_LUI   = 4'b1111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [CpuLen-1:0]   pc;
    logic [CpuLen-1:0]   rd1;
    logic [CpuLen-1:0]   rd2;
    logic [CpuLen-1:0]   imm_ext;
    logic [CpuRegAw-1:0] rs1;
    logic [CpuRegAw-1:0] rs2;
    logic [CpuRegAw-1:0] rd;
    alu_ctrl_t           alu_ctrl;
    logic                alu_src;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic [1:0]          result_src;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of all ID/EX stage signals except clock and reset.
//   slave  : view of the stage itself (decode/forward taps in, EX outputs out)
//   master : view of the surrounding pipeline (drives decode/taps, reads EX)
interface id_ex_stage_if
  import cpu_pkg::*;
#(
  parameter int unsigned LEN    = CpuLen,
  parameter int unsigned REG_AW = CpuRegAw
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [LEN-1:0]    id_pc;
  logic [LEN-1:0]    id_rd1;
  logic [LEN-1:0]    id_rd2;
  logic [LEN-1:0]    id_imm_ext;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  alu_ctrl_t         id_alu_ctrl;
  logic              id_alu_src;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_branch;
  logic              id_jump;
  logic [1:0]        id_result_src;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd;
  logic [LEN-1:0]    mem_fwd_data;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [LEN-1:0]    wb_data;
  logic [LEN-1:0]    aluop1;
  logic [LEN-1:0]    aluop2;
  alu_ctrl_t         alu_ctrl;
  logic              ex_valid;
  logic [LEN-1:0]    ex_pc;
  logic [LEN-1:0]    ex_imm_ext;
  logic [LEN-1:0]    ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_jump;
  logic [1:0]        ex_result_src;
  logic              hazard_stall;

  modport slave (
    input  stall, flush, id_valid, id_pc, id_rd1, id_rd2, id_imm_ext, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rd, id_alu_ctrl, id_alu_src, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_jump, id_result_src,
           mem_reg_write, mem_rd, mem_fwd_data, wb_reg_write, wb_rd, wb_data,
    output aluop1, aluop2, alu_ctrl, ex_valid, ex_pc, ex_imm_ext, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_result_src,
           hazard_stall
  );

  modport master (
    output stall, flush, id_valid, id_pc, id_rd1, id_rd2, id_imm_ext, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rd, id_alu_ctrl, id_alu_src, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_jump, id_result_src,
           mem_reg_write, mem_rd, mem_fwd_data, wb_reg_write, wb_rd, wb_data,
    input  aluop1, aluop2, alu_ctrl, ex_valid, ex_pc, ex_imm_ext, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_result_src,
           hazard_stall
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: operand bypass for one source register.
//   src/reg_val       : source index and value captured from the register file
//   mem_*/wb_*        : EX/MEM and MEM/WB write-back taps
//   data/sel          : selected operand and which tap supplied it
// With ID_EX_FORWARD_EN undefined the taps are ignored and data is reg_val.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int unsigned LEN    = CpuLen,
  parameter int unsigned REG_AW = CpuRegAw
) (
  input  logic [REG_AW-1:0] src,
  input  logic [LEN-1:0]    reg_val,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [LEN-1:0]    mem_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [LEN-1:0]    wb_data,
  output logic [LEN-1:0]    data,
  output fwd_sel_t          sel
);
`ifdef ID_EX_FORWARD_EN
  // x0 is never forwarded; MEM is younger than WB so it wins.
  always_comb begin
    sel = FWD_REG;
    if (src != '0) begin
      if (mem_reg_write && (mem_rd == src)) begin
        sel = FWD_MEM;
      end else if (wb_reg_write && (wb_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

  always_comb begin
    data = reg_val;
    unique case (sel)
      FWD_MEM: data = mem_data;
      FWD_WB:  data = wb_data;
      default: data = reg_val;
    endcase
  end
`else
  logic unused_taps;
  assign unused_taps = ^{src, mem_reg_write, mem_rd, mem_data, wb_reg_write, wb_rd, wb_data};
  assign sel  = FWD_REG;
  assign data = reg_val;
`endif
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus EX operand front end.
//   clk, rst : clock, synchronous active-high reset
//   bus      : id_ex_stage_if.slave (decode inputs, MEM/WB taps, stall/flush,
//              ALU operands, registered EX controls, hazard_stall)
// Register priority per edge: rst > stall (hold) > flush|hazard_stall (bubble) > load.
// Build option ID_EX_FORWARD_EN: enable MEM/WB operand forwarding. Without it,
// hazard_stall also covers every RAW match against EX, MEM and WB producers.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned LEN    = CpuLen,
  parameter int unsigned REG_AW = CpuRegAw
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);
  id_ex_t            ex_q, ex_d;
  logic [LEN-1:0]    rs1_val, rs2_val;
  fwd_sel_t          rs1_sel, rs2_sel;
  logic              load_use, raw_hazard, hazard;

  // The selects are only of interest when probing the pipeline.
  logic unused_sel;
  assign unused_sel = ^{rs1_sel, rs2_sel};

  // Decode slot holds a real instruction that reads register r (r != x0).
  function automatic logic id_reads(input logic [REG_AW-1:0] r);
    return bus.id_valid && (r != '0) &&
           ((bus.id_use_rs1 && (bus.id_rs1 == r)) || (bus.id_use_rs2 && (bus.id_rs2 == r)));
  endfunction

  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && id_reads(ex_q.rd);
`ifdef ID_EX_FORWARD_EN
    raw_hazard = 1'b0;
`else
    // No bypass anywhere: wait until every in-flight producer has retired.
    raw_hazard = (ex_q.valid && ex_q.reg_write && id_reads(ex_q.rd)) ||
                 (bus.mem_reg_write && id_reads(bus.mem_rd)) ||
                 (bus.wb_reg_write && id_reads(bus.wb_rd));
`endif
    hazard = load_use || raw_hazard;
  end

  always_comb begin
    ex_d = ex_q;
    if (!bus.stall) begin
      if (bus.flush || hazard) begin
        ex_d = '0;
      end else begin
        ex_d.valid      = bus.id_valid;
        ex_d.pc         = bus.id_pc;
        ex_d.rd1        = bus.id_rd1;
        ex_d.rd2        = bus.id_rd2;
        ex_d.imm_ext    = bus.id_imm_ext;
        ex_d.rs1        = bus.id_rs1;
        ex_d.rs2        = bus.id_rs2;
        ex_d.rd         = bus.id_rd;
        ex_d.alu_ctrl   = bus.id_alu_ctrl;
        ex_d.alu_src    = bus.id_alu_src;
        ex_d.reg_write  = bus.id_reg_write && bus.id_valid;
        ex_d.mem_read   = bus.id_mem_read && bus.id_valid;
        ex_d.mem_write  = bus.id_mem_write && bus.id_valid;
        ex_d.branch     = bus.id_branch && bus.id_valid;
        ex_d.jump       = bus.id_jump && bus.id_valid;
        ex_d.result_src = bus.id_result_src;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux #(.LEN(LEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .src           (ex_q.rs1),
    .reg_val       (ex_q.rd1),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_data      (bus.mem_fwd_data),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_data       (bus.wb_data),
    .data          (rs1_val),
    .sel           (rs1_sel)
  );

  fwd_mux #(.LEN(LEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .src           (ex_q.rs2),
    .reg_val       (ex_q.rd2),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_data      (bus.mem_fwd_data),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_data       (bus.wb_data),
    .data          (rs2_val),
    .sel           (rs2_sel)
  );

  assign bus.aluop1        = rs1_val;
  assign bus.aluop2        = ex_q.alu_src ? ex_q.imm_ext : rs2_val;
  assign bus.ex_store_data = rs2_val;
  assign bus.alu_ctrl      = ex_q.alu_ctrl;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_imm_ext    = ex_q.imm_ext;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_jump       = ex_q.jump;
  assign bus.ex_result_src = ex_q.result_src;
  assign bus.hazard_stall  = hazard;
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import cpu_pkg::*;

`ifdef ID_EX_FORWARD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.LEN(32), .REG_AW(5)) bus ();

  id_ex_stage #(.LEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference view of the instruction currently sitting in EX.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctrl;
    logic        alu_src, rw, mr, mw, br, jp;
    logic [1:0]  res;
  } slot_t;

  slot_t m;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Operand value an instruction in EX should see for source src.
  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] regv);
    if (FwdEn && src != 0 && bus.mem_reg_write && bus.mem_rd == src) return bus.mem_fwd_data;
    if (FwdEn && src != 0 && bus.wb_reg_write && bus.wb_rd == src) return bus.wb_data;
    return regv;
  endfunction

  function automatic logic reads(input logic [4:0] r);
    return bus.id_valid && r != 0 &&
           ((bus.id_use_rs1 && bus.id_rs1 == r) || (bus.id_use_rs2 && bus.id_rs2 == r));
  endfunction

  function automatic logic model_hazard();
    logic h;
    h = m.valid && m.mr && reads(m.rd);
    if (!FwdEn)
      h = h || (m.valid && m.rw && reads(m.rd)) || (bus.mem_reg_write && reads(bus.mem_rd)) ||
          (bus.wb_reg_write && reads(bus.wb_rd));
    return h;
  endfunction

  task automatic model_update();
    logic hz;
    hz = model_hazard();
    if (rst) m = '0;
    else if (!bus.stall) begin
      if (bus.flush || hz) m = '0;
      else begin
        m.valid = bus.id_valid;   m.pc = bus.id_pc;       m.rd1 = bus.id_rd1;
        m.rd2 = bus.id_rd2;       m.imm = bus.id_imm_ext; m.rs1 = bus.id_rs1;
        m.rs2 = bus.id_rs2;       m.rd = bus.id_rd;       m.ctrl = bus.id_alu_ctrl;
        m.alu_src = bus.id_alu_src;
        m.rw = bus.id_reg_write & bus.id_valid;
        m.mr = bus.id_mem_read & bus.id_valid;
        m.mw = bus.id_mem_write & bus.id_valid;
        m.br = bus.id_branch & bus.id_valid;
        m.jp = bus.id_jump & bus.id_valid;
        m.res = bus.id_result_src;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e1, e2;
    #1;
    e1 = fwd(m.rs1, m.rd1);
    e2 = fwd(m.rs2, m.rd2);
    chk({tag, ".aluop1"}, bus.aluop1, e1);
    chk({tag, ".aluop2"}, bus.aluop2, m.alu_src ? m.imm : e2);
    chk({tag, ".alu_ctrl"}, 32'(bus.alu_ctrl), 32'(m.ctrl));
    chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(m.valid));
    chk({tag, ".ex_pc"}, bus.ex_pc, m.pc);
    chk({tag, ".ex_imm_ext"}, bus.ex_imm_ext, m.imm);
    chk({tag, ".ex_store_data"}, bus.ex_store_data, e2);
    chk({tag, ".ex_rd"}, 32'(bus.ex_rd), 32'(m.rd));
    chk({tag, ".ex_reg_write"}, 32'(bus.ex_reg_write), 32'(m.rw));
    chk({tag, ".ex_mem_read"}, 32'(bus.ex_mem_read), 32'(m.mr));
    chk({tag, ".ex_mem_write"}, 32'(bus.ex_mem_write), 32'(m.mw));
    chk({tag, ".ex_branch"}, 32'(bus.ex_branch), 32'(m.br));
    chk({tag, ".ex_jump"}, 32'(bus.ex_jump), 32'(m.jp));
    chk({tag, ".ex_result_src"}, 32'(bus.ex_result_src), 32'(m.res));
    chk({tag, ".hazard_stall"}, 32'(bus.hazard_stall), 32'(model_hazard()));
  endtask

  task automatic rand_id();
    bus.id_valid      = ($urandom_range(0, 7) != 0);
    bus.id_pc         = $urandom;
    bus.id_rd1        = $urandom;
    bus.id_rd2        = $urandom;
    bus.id_imm_ext    = $urandom;
    bus.id_rs1        = 5'($urandom_range(0, 3));
    bus.id_rs2        = 5'($urandom_range(0, 3));
    bus.id_use_rs1    = 1'($urandom_range(0, 1));
    bus.id_use_rs2    = 1'($urandom_range(0, 1));
    bus.id_rd         = 5'($urandom_range(0, 3));
    bus.id_alu_ctrl   = alu_ctrl_t'(4'($urandom_range(0, 15)));
    bus.id_alu_src    = 1'($urandom_range(0, 1));
    bus.id_reg_write  = 1'($urandom_range(0, 1));
    bus.id_mem_read   = ($urandom_range(0, 2) == 0);
    bus.id_mem_write  = 1'($urandom_range(0, 1));
    bus.id_branch     = 1'($urandom_range(0, 1));
    bus.id_jump       = 1'($urandom_range(0, 1));
    bus.id_result_src = 2'($urandom_range(0, 3));
  endtask

  task automatic rand_taps();
    bus.mem_reg_write = 1'($urandom_range(0, 1));
    bus.mem_rd        = 5'($urandom_range(0, 3));
    bus.mem_fwd_data  = $urandom;
    bus.wb_reg_write  = 1'($urandom_range(0, 1));
    bus.wb_rd         = 5'($urandom_range(0, 3));
    bus.wb_data       = $urandom;
  endtask

  task automatic quiet_taps();
    bus.mem_reg_write = 1'b0; bus.mem_rd = 5'd0; bus.mem_fwd_data = 32'd0;
    bus.wb_reg_write  = 1'b0; bus.wb_rd  = 5'd0; bus.wb_data      = 32'd0;
  endtask

  // Plain register-register instruction with no side effects beyond rd.
  task automatic set_rr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] v1, input logic [31:0] v2);
    bus.id_valid = 1'b1;    bus.id_pc = 32'h100;     bus.id_imm_ext = 32'h0;
    bus.id_rs1 = rs1;       bus.id_rs2 = rs2;        bus.id_rd = rd;
    bus.id_rd1 = v1;        bus.id_rd2 = v2;
    bus.id_use_rs1 = 1'b1;  bus.id_use_rs2 = 1'b1;
    bus.id_alu_ctrl = ALU_ADD; bus.id_alu_src = 1'b0;
    bus.id_reg_write = 1'b1; bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0;
    bus.id_branch = 1'b0;   bus.id_jump = 1'b0;      bus.id_result_src = 2'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    rand_id();
    bus.id_valid = 1'b1;
    rand_taps();

    // Reset with a valid decode slot.
    cycle();
    cycle();
    check_all("reset");
    chk("reset.ex_valid_zero", 32'(bus.ex_valid), 32'd0);
    chk("reset.alu_ctrl_add", 32'(bus.alu_ctrl), 32'd0);
    rst = 1'b0;

    // add x6,x5,x1 with addi x5 (=7) in EX/MEM.
    quiet_taps();
    set_rr(5'd5, 5'd1, 5'd6, 32'd0, 32'd3);
    bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd5; bus.mem_fwd_data = 32'd7;
    cycle();
    check_all("t2");
    chk("t2.aluop1_fwd", bus.aluop1, FwdEn ? 32'd7 : 32'd0);
    chk("t2.aluop2_rs2", bus.aluop2, FwdEn ? 32'd3 : 32'd0);

    // MEM beats WB; x0 never forwarded.
    bus.mem_fwd_data = 32'd9;
    bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'd4;
    cycle();
    check_all("t3a");
    chk("t3.mem_over_wb", bus.aluop1, FwdEn ? 32'd9 : 32'd0);
    quiet_taps();
    set_rr(5'd0, 5'd1, 5'd6, 32'd0, 32'd3);
    bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd0; bus.mem_fwd_data = 32'hFF;
    cycle();
    check_all("t3b");
    chk("t3.x0_zero", bus.aluop1, 32'd0);

    // Load-use: lw x5 then add x7,x5,x5.
    quiet_taps();
    set_rr(5'd2, 5'd0, 5'd5, 32'h40, 32'd0);
    bus.id_use_rs2 = 1'b0; bus.id_mem_read = 1'b1; bus.id_result_src = 2'd1;
    cycle();
    set_rr(5'd5, 5'd5, 5'd7, 32'h11, 32'h11);
    check_all("t4.lw");
    chk("t4.hazard", 32'(bus.hazard_stall), 32'd1);
    cycle();
    bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd5; bus.mem_fwd_data = 32'h55;
    check_all("t4.bubble");
    chk("t4.bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("t4.one_bubble", 32'(bus.hazard_stall), FwdEn ? 32'd0 : 32'd1);
    for (int k = 0; k < 4; k++) begin
      logic hz;
      hz = model_hazard();
      cycle();
      if (!hz) bus.id_valid = 1'b0;   // consumer left ID
      quiet_taps();
      if (k == 0) begin bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h55; end
      check_all("t4.drain");
    end

    // Flush kills a valid sub; flush under stall holds contents.
    quiet_taps();
    set_rr(5'd0, 5'd0, 5'd8, 32'd20, 32'd5);
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.id_alu_ctrl = ALU_SUB;
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    check_all("t5.flush");
    chk("t5.flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("t5.flush_rw", 32'(bus.ex_reg_write), 32'd0);
    cycle();
    check_all("t5.load");
    bus.stall = 1'b1; bus.flush = 1'b1;
    rand_id();
    cycle();
    check_all("t5.hold");
    chk("t5.hold_valid", 32'(bus.ex_valid), 32'd1);
    chk("t5.hold_rd", 32'(bus.ex_rd), 32'd8);
    bus.stall = 1'b0; bus.flush = 1'b0;

    // Reset while a store-ish instruction sits in EX.
    set_rr(5'd0, 5'd0, 5'd3, 32'd1, 32'd2);
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.id_mem_write = 1'b1;
    cycle();
    check_all("t7.loaded");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_all("t7.rst");
    chk("t7.rst_mw", 32'(bus.ex_mem_write), 32'd0);
    chk("t7.rst_rw", 32'(bus.ex_reg_write), 32'd0);

    // Random traffic with frequent register collisions.
    for (int i = 0; i < 400; i++) begin
      rand_id();
      rand_taps();
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      check_all("rand");
      cycle();
    end
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
